// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } seg7_arb_state_e;

    localparam logic [15:0] SEG7_BLANK_WORD = 16'hBBBB;
    localparam logic [15:0] SEG7_DASH_WORD  = 16'hAAAA;

    function automatic int seg7_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_rr_pick.sv
// Combinational round-robin selector: first requester after ptr, wrapping.
module seg7_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [2:0]       gnt_idx,
    output logic             gnt_vld
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Walk from the farthest candidate inward so the nearest one wins last.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[IDX_W'((int'(ptr) + i) % N_REQ)]) begin
                gnt_idx = 3'((int'(ptr) + i) % N_REQ);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_disp_arb.sv
// Round-robin time-sharing of the 4-digit seven-segment display among requesters.
// Optional build macro SEG7_ARB_PRIO_EN: requester 0 preempts on a rising request.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner, display blank, waiting for any request
// HOLD    | owner on screen for HOLD_CYCLES, x_o follows owner's word
// GAP     | blank display for GAP_CYCLES before handing to a new owner
module seg7_disp_arb
    import seg7_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 5_000_000
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [16*N_REQ-1:0]  data_i,
    output logic [N_REQ-1:0]     ack_o,
    output logic [15:0]          x_o,
    output logic                 clr_o,
    output logic [2:0]           owner_o,
    output logic                 busy_o
);

    localparam int CNT_MAX = seg7_max(HOLD_CYCLES, GAP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam bit               GAP_EN    = (GAP_CYCLES > 0);

    seg7_arb_state_e  state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       ptr;

    logic [2:0]       pick_idx;
    logic             pick_vld;
    logic [7:0]       req_ext;
    logic [15:0]      words [8];
    logic             hold_done;
    logic             gap_done;
    logic             others_pend;
    logic             preempt;

    logic             take_grant;
    logic [2:0]       gnt_sel;
    logic             upd_ptr;

    seg7_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (req_i),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    // Pad to 8 slots so owner_o indexes without width juggling.
    for (genvar k = 0; k < 8; k++) begin : g_words
        if (k < N_REQ) begin : g_live
            assign words[k] = data_i[16*k +: 16];
        end else begin : g_pad
            assign words[k] = '0;
        end
    end

    assign req_ext     = 8'(req_i);
    assign hold_done   = (cnt == HOLD_LAST);
    assign gap_done    = (cnt == GAP_LAST);
    assign others_pend = |(req_ext & ~(8'b1 << owner_o));

`ifdef SEG7_ARB_PRIO_EN
    logic req0_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            req0_q <= 1'b0;
        end else begin
            req0_q <= req_i[0];
        end
    end

    assign preempt = req_i[0] & ~req0_q &
                     (((state == ST_HOLD) && (owner_o != 3'd0)) || (state == ST_GAP));
`else
    assign preempt = 1'b0;
`endif

    // Every path that starts a new grant funnels through here so ack/clr stay coincident.
    always_comb begin
        take_grant = 1'b0;
        gnt_sel    = pick_idx;
        upd_ptr    = 1'b1;
        if (preempt) begin
            take_grant = 1'b1;
            gnt_sel    = 3'd0;
            upd_ptr    = 1'b0;
        end else begin
            case (state)
                ST_IDLE: take_grant = pick_vld;
                ST_HOLD: take_grant = hold_done && others_pend && !GAP_EN;
                ST_GAP:  take_grant = gap_done && pick_vld;
                default: take_grant = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ptr     <= 3'(N_REQ - 1);
            x_o     <= SEG7_BLANK_WORD;
            ack_o   <= '0;
            clr_o   <= 1'b0;
            owner_o <= '0;
            busy_o  <= 1'b0;
        end else begin
            ack_o <= '0;
            clr_o <= 1'b0;
            if (take_grant) begin
                state   <= ST_HOLD;
                cnt     <= '0;
                owner_o <= gnt_sel;
                x_o     <= words[gnt_sel];
                ack_o   <= N_REQ'(1) << gnt_sel;
                clr_o   <= 1'b1;
                busy_o  <= 1'b1;
                if (upd_ptr) begin
                    ptr <= gnt_sel;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        x_o    <= SEG7_BLANK_WORD;
                        busy_o <= 1'b0;
                    end
                    ST_HOLD: begin
                        if (hold_done) begin
                            if (others_pend) begin
                                state  <= ST_GAP;
                                cnt    <= '0;
                                x_o    <= SEG7_BLANK_WORD;
                                busy_o <= 1'b0;
                            end else if (req_ext[owner_o]) begin
                                cnt <= '0;
                                x_o <= words[owner_o];
                            end else begin
                                state  <= ST_IDLE;
                                x_o    <= SEG7_BLANK_WORD;
                                busy_o <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (req_ext[owner_o]) begin
                                x_o <= words[owner_o];
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_done) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        x_o    <= SEG7_BLANK_WORD;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_disp_arb.sv
// Bench for seg7_disp_arb: directed scenarios plus random traffic against a behavioural model.
module tb_seg7_disp_arb;

    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam int GAP  = 2;
`ifdef SEG7_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_i = '0;
    logic [16*N-1:0]   data_i = '0;
    logic [N-1:0]      ack_o;
    logic [15:0]       x_o;
    logic              clr_o;
    logic [2:0]        owner_o;
    logic              busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    seg7_disp_arb #(
        .N_REQ       (N),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk     (clk),
        .rst_i   (rst),
        .req_i   (req_i),
        .data_i  (data_i),
        .ack_o   (ack_o),
        .x_o     (x_o),
        .clr_o   (clr_o),
        .owner_o (owner_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 showing an owner, 2 blank gap; m_left = cycles still to run.
    int           m_phase, m_left, m_owner, m_ptr;
    logic [15:0]  m_x;
    logic [N-1:0] m_ack;
    logic         m_clr, m_busy, m_r0prev;

    function automatic logic [15:0] word(input int k);
        return 16'(data_i >> (16 * k));
    endfunction

    function automatic bit req_bit(input logic [N-1:0] r, input int k);
        return ((r >> k) & 1) != 0;
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 1; i <= N; i++) begin
            if (req_bit(r, (p + i) % N)) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic m_grant(input int w, input bit upd);
        m_phase = 1;
        m_left  = HOLD;
        m_owner = w;
        if (upd) m_ptr = w;
        m_x     = word(w);
        m_ack   = N'(1) << w;
        m_clr   = 1'b1;
        m_busy  = 1'b1;
    endtask

    task automatic m_reset();
        m_phase = 0; m_left = 0; m_owner = 0; m_ptr = N - 1;
        m_x = 16'hBBBB; m_ack = '0; m_clr = 1'b0; m_busy = 1'b0; m_r0prev = 1'b0;
    endtask

    task automatic m_step();
        bit rise;
        int w;
        rise     = PRIO && req_i[0] && !m_r0prev;
        m_r0prev = req_i[0];
        m_ack    = '0;
        m_clr    = 1'b0;
        if (rise && ((m_phase == 1 && m_owner != 0) || m_phase == 2)) begin
            m_grant(0, 1'b0);
        end else if (m_phase == 0) begin
            w = pick(req_i, m_ptr);
            if (w >= 0) m_grant(w, 1'b1);
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                if ((req_i & ~(N'(1) << m_owner)) != 0) begin
                    if (GAP == 0) m_grant(pick(req_i, m_ptr), 1'b1);
                    else begin
                        m_phase = 2; m_left = GAP; m_x = 16'hBBBB; m_busy = 1'b0;
                    end
                end else if (req_bit(req_i, m_owner)) begin
                    m_left = HOLD;
                    m_x    = word(m_owner);
                end else begin
                    m_phase = 0; m_x = 16'hBBBB; m_busy = 1'b0;
                end
            end else if (req_bit(req_i, m_owner)) begin
                m_x = word(m_owner);
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                w = pick(req_i, m_ptr);
                if (w >= 0) m_grant(w, 1'b1);
                else m_phase = 0;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("x_o", 32'(x_o), 32'(m_x));
                check("ack_o", 32'(ack_o), 32'(m_ack));
                check("clr_o", 32'(clr_o), 32'(m_clr));
                check("busy_o", 32'(busy_o), 32'(m_busy));
                if (m_busy) check("owner_o", 32'(owner_o), 32'(m_owner));
            end
        end
    end

    task automatic expect_grant(input string name, input int exp_owner, input int max_cyc, output int n);
        for (n = 1; n <= max_cyc; n++) begin
            @(posedge clk);
            #1;
            if (ack_o != '0) break;
        end
        check({name, "_ack"}, 32'(ack_o), 32'(N'(1) << exp_owner));
        check({name, "_clr"}, 32'(clr_o), 32'd1);
        check({name, "_owner"}, 32'(owner_o), 32'(exp_owner));
    endtask

    initial begin
        int n, n_busy, n_ack;
        repeat (3) @(negedge clk);
        check("rst_x", 32'(x_o), 32'h0000_BBBB);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_clr", 32'(clr_o), 32'd0);
        check("rst_owner", 32'(owner_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;

        // first grant, then the same owner keeps the screen without a new ack
        @(negedge clk);
        data_i[15:0] = 16'h1234;
        req_i = 4'b0001;
        @(posedge clk); #1;
        check("s1_x", 32'(x_o), 32'h0000_1234);
        check("s1_ack", 32'(ack_o), 32'b0001);
        check("s1_clr", 32'(clr_o), 32'd1);
        check("s1_busy", 32'(busy_o), 32'd1);
        n_busy = 0; n_ack = 0;
        repeat (20) begin
            @(posedge clk); #1;
            n_busy += int'(busy_o);
            n_ack  += int'(ack_o != '0);
        end
        check("s1_busy_cont", 32'(n_busy), 32'd20);
        check("s1_no_reack", 32'(n_ack), 32'd0);

        // live data follows with one cycle of latency, freezes when request drops
        @(negedge clk); data_i[15:0] = 16'h0005;
        @(posedge clk); #1; check("s3_x5", 32'(x_o), 32'h0005);
        @(negedge clk); data_i[15:0] = 16'h0006;
        @(posedge clk); #1; check("s3_x6", 32'(x_o), 32'h0006);
        @(negedge clk); req_i = '0; data_i[15:0] = 16'h0007;
        @(posedge clk); #1; check("s3_frozen", 32'(x_o), 32'h0006);
        for (int i = 0; i < 2 * HOLD; i++) begin
            @(posedge clk); #1;
            if (!busy_o) break;
        end
        check("s3_idle_busy", 32'(busy_o), 32'd0);
        check("s3_idle_x", 32'(x_o), 32'h0000_BBBB);

        // two requesters alternate with a blank gap between them
        @(negedge clk);
        data_i = 64'h4444_3333_2222_1111;
        req_i = 4'b0110;
        expect_grant("s2_g1", 1, 3, n);
        check("s2_lat", 32'(n), 32'd1);
        check("s2_x1", 32'(x_o), 32'h2222);
        expect_grant("s2_g2", 2, 20, n);
        check("s2_gap2", 32'(n), 32'(HOLD + GAP));
        expect_grant("s2_g3", 1, 20, n);
        check("s2_gap3", 32'(n), 32'(HOLD + GAP));

        // asynchronous reset in the middle of a hold
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("s5_x", 32'(x_o), 32'h0000_BBBB);
        check("s5_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_i = 4'b1111;

        // full rotation after reset starts at requester 0
        expect_grant("s4_g0", 0, 3, n);
        check("s4_lat", 32'(n), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            expect_grant("s4_rr", k % N, 20, n);
            check("s4_spacing", 32'(n), 32'(HOLD + GAP));
        end

`ifdef SEG7_ARB_PRIO_EN
        @(negedge clk); rst = 1'b1; req_i = '0;
        @(negedge clk); rst = 1'b0; req_i = 4'b1100;
        expect_grant("p_g2", 2, 3, n);
        repeat (2) @(posedge clk);
        @(negedge clk); req_i = 4'b1101;
        expect_grant("p_pre", 0, 1, n);
        check("p_pre_lat", 32'(n), 32'd1);
        expect_grant("p_next", 3, 20, n);
        check("p_next_gap", 32'(n), 32'(HOLD + GAP));
`endif

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) req_i = N'($urandom);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) data_i[16*k +: 16] = 16'($urandom);
            end
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, expected end before 1ms");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
